// File: rtl/ws_frame_queue_pkg.sv
// ----------------------------------------------------------------------------
// ws_frame_queue_pkg
//   Shared definitions for the jitter record queue: launcher FSM state
//   encoding, payload size and the record width helper.
//   Record layout (MSB..LSB): {seq[15:0], pcnt[Nc-1:0], jtr1, jtr2, jtr3, jtr4}
// ----------------------------------------------------------------------------
package ws_frame_queue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_ACK   = 3'd3,
    ST_BUSY  = 3'd4
  } fq_state_t;

  // Payload length in bytes served to udp_send
  localparam int P_SZ  = 18;
  localparam int SEQ_W = 16;

  function automatic int rec_width(input int nm, input int nc);
    return SEQ_W + nc + 4 * nm;
  endfunction

endpackage

// File: rtl/ws_frame_queue_if.sv
// ----------------------------------------------------------------------------
// ws_frame_queue_if
//   Bundles the trigger/snapshot inputs, the udp_send handshake and the
//   queue status of ws_frame_queue.
//   master : jitter evaluators + udp_send side (drives wr, data, udp_rdy, addr)
//   slave  : the queue (drives udp_start, payload, level, full, drop_cnt)
//   Handshake: wr is a single-cycle strobe, data sampled on the same edge.
//   udp_start is a one-cycle pulse issued only while udp_rdy reported idle;
//   payload is combinational from addr and stays valid for the whole frame.
// ----------------------------------------------------------------------------
interface ws_frame_queue_if #(
  parameter int Nd  = 3,
  parameter int Nm  = 16,
  parameter int Nc  = 32,
  parameter int Nsz = 7
);
  logic           wr;
  logic [Nc-1:0]  pcnt;
  logic [Nm-1:0]  jtr1;
  logic [Nm-1:0]  jtr2;
  logic [Nm-1:0]  jtr3;
  logic [Nm-1:0]  jtr4;
  logic           udp_rdy;
  logic           udp_start;
  logic [Nsz-1:0] addr;
  logic [7:0]     payload;
  logic [Nd:0]    level;
  logic           full;
  logic [15:0]    drop_cnt;

  modport master (
    output wr, pcnt, jtr1, jtr2, jtr3, jtr4, udp_rdy, addr,
    input  udp_start, payload, level, full, drop_cnt
  );

  modport slave (
    input  wr, pcnt, jtr1, jtr2, jtr3, jtr4, udp_rdy, addr,
    output udp_start, payload, level, full, drop_cnt
  );
endinterface

// File: rtl/ws_frame_queue_rec_fifo.sv
// ----------------------------------------------------------------------------
// ws_frame_queue_rec_fifo
//   2^Nd x RW record store with synchronous read. Owns the pointers, the
//   occupancy count and the overflow policy.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     wr_i         write strobe, wr_data_i stored when accepted
//     pop_i        read head into rd_data_o on this edge and advance
//     rd_data_o    registered head record
//     level_o      records held, full_o when level_o == 2^Nd
//     accept_o     this write is stored (seq must advance)
//     drop_o       this write hit a full queue without a pop
//   Macro WS_QUEUE_OVERWRITE_EN: a write while full replaces the oldest
//   record instead of being discarded.
// ----------------------------------------------------------------------------
module ws_frame_queue_rec_fifo #(
  parameter int Nd = 3,
  parameter int RW = 112
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [RW-1:0] wr_data_i,
  input  logic          pop_i,
  output logic [RW-1:0] rd_data_o,
  output logic [Nd:0]   level_o,
  output logic          full_o,
  output logic          accept_o,
  output logic          drop_o
);
  localparam int DEPTH = 1 << Nd;
  localparam logic [Nd-1:0] PTR_ONE  = Nd'(1);
  localparam logic [Nd:0]   LVL_ONE  = (Nd+1)'(1);
  localparam logic [Nd:0]   LVL_FULL = (Nd+1)'(DEPTH);

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] rd_data_q;
  logic [Nd-1:0] wr_ptr_q, wr_ptr_d;
  logic [Nd-1:0] rd_ptr_q, rd_ptr_d;
  logic [Nd:0]   level_q, level_d;
  logic          full_w, pop_ok, store, drop;

  assign full_w = (level_q == LVL_FULL);
  assign pop_ok = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    store    = 1'b0;
    drop     = 1'b0;
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_i) begin
      // A pop on the same edge frees the slot, so a full queue still accepts
      if (!full_w || pop_ok) begin
        store = 1'b1;
      end else begin
        drop = 1'b1;
`ifdef WS_QUEUE_OVERWRITE_EN
        // Replace the oldest record: both pointers advance, level stays full
        store    = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
      end
    end
    if (store) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (store && !drop && !pop_ok)  level_d = level_q + LVL_ONE;
    else if (pop_ok && !store)      level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      // Read-before-write on a shared address returns the old head
      if (pop_ok) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;
  assign full_o    = full_w;
  assign accept_o  = store;
  assign drop_o    = drop;

endmodule

// File: rtl/ws_frame_queue.sv
// ----------------------------------------------------------------------------
// ws_frame_queue
//   Record queue between the jitter evaluators and udp_send. Each wr pulse
//   snapshots {seq, pcnt, jtr1..jtr4}; one UDP frame is launched per queued
//   record whenever udp_send is idle, and the 18-byte payload is served by
//   byte address from the in-flight record.
//   Ports:
//     clk          100 MHz system clock
//     rst          asynchronous active-low reset (0 = reset)
//     bus          ws_frame_queue_if.slave: wr/pcnt/jtr1..4 snapshot inputs,
//                  udp_rdy/udp_start/addr/payload to udp_send,
//                  level/full/drop_cnt status
//     dbg_state_o  launcher FSM state
//   Payload (LSB first): 0-3 pcnt, 4-11 jtr1..jtr4, 12-13 seq,
//   14-15 drop_cnt, 16 level, 17 {7'b0, full}, others 00.
//   Macro WS_QUEUE_OVERWRITE_EN: writes into a full queue replace the oldest
//   record; undefined, they are discarded. drop_cnt counts them either way.
// ----------------------------------------------------------------------------
module ws_frame_queue
  import ws_frame_queue_pkg::*;
#(
  parameter int Nd  = 3,
  parameter int Nm  = 16,
  parameter int Nc  = 32,
  parameter int Nsz = 7
) (
  input  logic            clk,
  input  logic            rst,
  ws_frame_queue_if.slave bus,
  output fq_state_t       dbg_state_o
);
  localparam int RW = rec_width(Nm, Nc);

  fq_state_t        state_q;
  logic             udp_start_q;
  logic [RW-1:0]    cur_q;
  logic [15:0]      seq_q;
  logic [15:0]      drop_q;
  logic [RW-1:0]    head_w;
  logic [Nd:0]      level_w;
  logic             full_w, accept_w, drop_w, pop_w;
  logic [8*P_SZ-1:0] pl_vec;
  logic [7:0]       payload_w;

  // The head is popped while in LOAD; its data is valid in START
  assign pop_w = (state_q == ST_LOAD);

  ws_frame_queue_rec_fifo #(
    .Nd (Nd),
    .RW (RW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (bus.wr),
    .wr_data_i ({seq_q, bus.pcnt, bus.jtr1, bus.jtr2, bus.jtr3, bus.jtr4}),
    .pop_i     (pop_w),
    .rd_data_o (head_w),
    .level_o   (level_w),
    .full_o    (full_w),
    .accept_o  (accept_w),
    .drop_o    (drop_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      udp_start_q <= 1'b0;
      cur_q       <= '0;
    end else begin
      udp_start_q <= 1'b0;
      case (state_q)
        ST_IDLE:  if ((level_w != '0) && bus.udp_rdy) state_q <= ST_LOAD;
        ST_LOAD:  state_q <= ST_START;
        ST_START: begin
          // cur holds until the next LOAD, covering the whole frame
          cur_q       <= head_w;
          udp_start_q <= 1'b1;
          state_q     <= ST_ACK;
        end
        ST_ACK:   if (!bus.udp_rdy) state_q <= ST_BUSY;
        ST_BUSY:  if (bus.udp_rdy) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      if (accept_w) seq_q <= seq_q + 16'd1;
      if (drop_w && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Record fields of the in-flight frame
  logic [15:0]   cur_seq;
  logic [Nc-1:0] cur_pcnt;
  logic [Nm-1:0] cur_j1, cur_j2, cur_j3, cur_j4;

  assign cur_seq  = cur_q[RW-1 -: 16];
  assign cur_pcnt = cur_q[4*Nm +: Nc];
  assign cur_j1   = cur_q[3*Nm +: Nm];
  assign cur_j2   = cur_q[2*Nm +: Nm];
  assign cur_j3   = cur_q[Nm +: Nm];
  assign cur_j4   = cur_q[0 +: Nm];

  assign pl_vec = {7'b0, full_w, 8'(level_w), drop_q, cur_seq,
                   16'(cur_j4), 16'(cur_j3), 16'(cur_j2), 16'(cur_j1),
                   32'(cur_pcnt)};

  always_comb begin
    payload_w = 8'h00;
    for (int i = 0; i < P_SZ; i++) begin
      if (bus.addr == Nsz'(i)) payload_w = pl_vec[8*i +: 8];
    end
  end

  assign bus.udp_start = udp_start_q;
  assign bus.payload   = payload_w;
  assign bus.level     = level_w;
  assign bus.full      = full_w;
  assign bus.drop_cnt  = drop_q;
  assign dbg_state_o   = state_q;

endmodule
